// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin sharing of one fixed-latency pipelined shifter with tagged result return
module barrel_shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ = 4,
  parameter int LATENCY = 5,
  localparam int SW = $clog2(WIDTH),
  localparam int TW = $clog2(NREQ)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] ReqIn,
  input  logic [NREQ*SW-1:0]    ReqShiftAmount,
  input  logic [NREQ-1:0]       ReqShiftIn,
  input  logic                  Hold,
  output logic [NREQ-1:0]       Grant,
  output logic [WIDTH-1:0]      ShIn,
  output logic [SW-1:0]         ShShiftAmount,
  output logic                  ShShiftIn,
  input  logic [WIDTH-1:0]      ShOut,
  output logic [NREQ-1:0]       RspValid,
  output logic [WIDTH-1:0]      RspData,
  output logic                  Busy
);
  logic [TW-1:0] ptr, idx, c;
  logic          found, gnt_any;
  logic [LATENCY:0] vld;
  logic [TW-1:0] tag_q [LATENCY+1];
  // Scan downward so the last hit is the requester closest after ptr.
  always_comb begin
    idx = ptr;
    found = 1'b0;
    c = '0;
    for (int i = NREQ; i >= 1; i--) begin
      c = TW'((int'(ptr) + i) % NREQ);
      if (Req[c]) begin
        found = 1'b1;
        idx = c;
      end
    end
    gnt_any = found && !Hold && !Reset;
    Grant = gnt_any ? NREQ'(1) << idx : '0;
  end
  assign Busy = |vld;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr <= TW'(NREQ - 1);
      ShIn <= '0;
      ShShiftAmount <= '0;
      ShShiftIn <= 1'b0;
      vld <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
      RspValid <= '0;
      RspData <= '0;
    end else begin
      if (gnt_any) begin
        ptr <= idx;
        ShIn <= ReqIn[idx*WIDTH +: WIDTH];
        ShShiftAmount <= ReqShiftAmount[idx*SW +: SW];
        ShShiftIn <= ReqShiftIn[idx];
      end
      vld <= {vld[LATENCY-1:0], gnt_any};
      tag_q[0] <= idx;
      for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
      RspValid <= vld[LATENCY] ? NREQ'(1) << tag_q[LATENCY] : '0;
      if (vld[LATENCY]) RspData <= ShOut;
    end
  end
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb_barrel_shift_arbiter: random and directed traffic against a scoreboard fed by a reference requester/arbiter model
module tb_barrel_shift_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ = 4;
  localparam int LATENCY = 5;
  localparam int SW = $clog2(WIDTH);
  typedef struct {int who; logic [WIDTH-1:0] data; int at;} exp_t;
  logic Clock = 1'b0, Reset = 1'b1, Hold = 1'b0;
  logic [NREQ-1:0] Req = '0, ReqShiftIn = '0, Grant, RspValid;
  logic [NREQ*WIDTH-1:0] ReqIn = '0;
  logic [NREQ*SW-1:0] ReqShiftAmount = '0;
  logic [WIDTH-1:0] ShIn, ShOut, RspData;
  logic [SW-1:0] ShShiftAmount;
  logic ShShiftIn, Busy;
  int vectors = 0, miscompares = 0, cyc = 0, gcnt = 0, rcnt = 0, ptr_m = NREQ - 1;
  exp_t q[$];
  exp_t me;
  bit be, refill = 0;
  logic [NREQ-1:0] pend = '0;
  logic [WIDTH-1:0] op_in [NREQ];
  logic [SW-1:0] op_amt [NREQ];
  logic op_fill [NREQ];
  logic [WIDTH-1:0] sh_in_e = '0;
  logic [SW-1:0] sh_amt_e = '0;
  logic sh_fill_e = 1'b0;
  logic [WIDTH-1:0] pipe [LATENCY];

  barrel_shift_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .ReqIn(ReqIn), .ReqShiftAmount(ReqShiftAmount),
    .ReqShiftIn(ReqShiftIn), .Hold(Hold), .Grant(Grant), .ShIn(ShIn), .ShShiftAmount(ShShiftAmount),
    .ShShiftIn(ShShiftIn), .ShOut(ShOut), .RspValid(RspValid), .RspData(RspData), .Busy(Busy));

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] shf(input logic [WIDTH-1:0] a, input logic [SW-1:0] s, input logic f);
    logic [2*WIDTH-1:0] m;
    m = ((2*WIDTH)'(a) << s) | (f ? ((2*WIDTH)'(1) << s) - 1 : '0);
    return m[WIDTH-1:0];
  endfunction

  // Shifter stand-in: samples its inputs every edge, result appears LATENCY edges later.
  always @(posedge Clock) begin
    pipe[0] <= shf(ShIn, ShShiftAmount, ShShiftIn);
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign ShOut = pipe[LATENCY-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge Clock) if (!Reset) begin
    chk("grant_onehot0", 64'($onehot0(Grant)), 64'd1);
    if (RspValid != '0) begin
      rcnt++;
      if (q.size() == 0) chk("stale_rsp", 64'(RspValid), 64'd0);
      else begin
        me = q.pop_front();
        chk("rsp_valid", 64'(RspValid), 64'(NREQ'(1) << me.who));
        chk("rsp_data", 64'(RspData), 64'(me.data));
        chk("rsp_cycle", 64'(cyc), 64'(me.at));
      end
    end else if (q.size() != 0 && q[0].at <= cyc) begin
      me = q.pop_front();
      chk("rsp_missing", 64'(RspValid), 64'(NREQ'(1) << me.who));
    end
    be = 0;
    foreach (q[j]) if (q[j].at <= cyc + LATENCY + 1) be = 1;
    chk("busy", 64'(Busy), 64'(be));
  end

  task automatic set_op(input int i, input logic [WIDTH-1:0] d, input int a, input logic f);
    pend[i] = 1'b1;
    op_in[i] = d;
    op_amt[i] = SW'(a);
    op_fill[i] = f;
  endtask

  task automatic new_op(input int i);
    set_op(i, $urandom, $urandom_range(0, WIDTH - 1), 1'($urandom));
  endtask

  task automatic drive(input logic h);
    Hold = h;
    Req = pend;
    for (int i = 0; i < NREQ; i++) begin
      ReqIn[i*WIDTH +: WIDTH] = op_in[i];
      ReqShiftAmount[i*SW +: SW] = op_amt[i];
      ReqShiftIn[i] = op_fill[i];
    end
  endtask

  task automatic step(input logic h);
    int g, k;
    chk("sh_in", 64'(ShIn), 64'(sh_in_e));
    chk("sh_amt", 64'(ShShiftAmount), 64'(sh_amt_e));
    chk("sh_fill", 64'(ShShiftIn), 64'(sh_fill_e));
    drive(h);
    #1;
    g = -1;
    if (!h) for (int j = 1; j <= NREQ; j++) begin
      k = (ptr_m + j) % NREQ;
      if (g < 0 && pend[k]) g = k;
    end
    chk("grant", 64'(Grant), g < 0 ? 64'd0 : 64'(NREQ'(1) << g));
    if (g >= 0) begin
      q.push_back('{g, shf(op_in[g], op_amt[g], op_fill[g]), cyc + LATENCY + 2});
      ptr_m = g;
      sh_in_e = op_in[g];
      sh_amt_e = op_amt[g];
      sh_fill_e = op_fill[g];
      pend[g] = 1'b0;
      gcnt++;
      if (refill) new_op(g);
    end
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive(1'b0);
    #1;
    chk("rst_grant", 64'(Grant), 64'd0);
    chk("rst_rspvalid", 64'(RspValid), 64'd0);
    chk("rst_rspdata", 64'(RspData), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_shin", 64'({ShIn, ShShiftAmount, ShShiftIn}), 64'd0);
    q.delete();
    ptr_m = NREQ - 1;
    sh_in_e = '0;
    sh_amt_e = '0;
    sh_fill_e = 1'b0;
    gcnt = 0;
    rcnt = 0;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && q.size() != 0; n++) step(1'b0);
    chk("drain", 64'(q.size()), 64'd0);
    step(1'b0);
    chk("idle_busy", 64'(Busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_op(i, '0, 0, 1'b0);
    @(negedge Clock);
    do_reset();
    pend = '0;
    set_op(0, 32'h0000_0001, 4, 1'b0);
    step(1'b0);
    drain();
    refill = 1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    repeat (8) step(1'b0);
    refill = 0;
    pend = '0;
    drain();
    set_op(2, 32'h8000_0001, 31, 1'b1);
    step(1'b0);
    set_op(2, 32'h8000_0001, 0, 1'b1);
    step(1'b0);
    drain();
    do_reset();
    new_op(0);
    new_op(2);
    repeat (3) step(1'b1);
    step(1'b0);
    step(1'b0);
    drain();
    pend = '0;
    new_op(0);
    new_op(1);
    new_op(2);
    repeat (4) step(1'b0);
    do_reset();
    set_op(1, $urandom, $urandom_range(0, WIDTH - 1), 1'($urandom));
    step(1'b0);
    drain();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) new_op(i);
        else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
      step($urandom_range(0, 7) == 0);
    end
    pend = '0;
    drain();
    chk("grant_rsp_count", 64'(rcnt), 64'(gcnt));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
